// File: rtl/baw_pkg.sv
// Shared definitions for the black-and-white card match engine:
// FSM state encoding, round/game result codes and play-reject codes.
package baw_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_LEAD    = 3'd1,
        ST_FOLLOW  = 3'd2,
        ST_RESOLVE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Round / game outcome encodings
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    // Reject reasons, listed in priority order
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_TURN  = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_USED  = 2'b11;

endpackage

// File: rtl/baw_hand.sv
// One player's hand: unused-card mask plus black/white unused-card counts.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   load                - reload a full hand (new game)
//   take                - consume the card on 'card' (caller guarantees it is legal)
//   card                - card value to consume
//   mask                - bit v set while card v is still unused
//   black_cnt/white_cnt - unused cards per colour (odd values are black)
module baw_hand #(
    parameter int unsigned NUM_CARDS = 9,
    parameter int unsigned CW        = $clog2(NUM_CARDS),
    parameter int unsigned NW        = $clog2(NUM_CARDS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 take,
    input  logic [CW-1:0]        card,
    output logic [NUM_CARDS-1:0] mask,
    output logic [NW-1:0]        black_cnt,
    output logic [NW-1:0]        white_cnt
);

    localparam logic [NW-1:0]        BLACK_INIT = NW'(NUM_CARDS / 2);
    localparam logic [NW-1:0]        WHITE_INIT = NW'(NUM_CARDS - NUM_CARDS / 2);
    localparam logic [NUM_CARDS-1:0] ONE_HOT0   = NUM_CARDS'(1);

    // Hand state; reset and load both restore a full hand
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask      <= '1;
            black_cnt <= BLACK_INIT;
            white_cnt <= WHITE_INIT;
        end else if (load) begin
            mask      <= '1;
            black_cnt <= BLACK_INIT;
            white_cnt <= WHITE_INIT;
        end else if (take) begin
            mask <= mask & ~(ONE_HOT0 << card);
            if (card[0]) begin
                black_cnt <= black_cnt - NW'(1);
            end else begin
                white_cnt <= white_cnt - NW'(1);
            end
        end
    end

endmodule

// File: rtl/baw_match_engine.sv
// Two-player black-and-white card match engine. Players alternately play
// cards (leader first); the higher card wins the round and leads the next.
// The game ends after NUM_ROUNDS rounds or once the outcome is decided.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   start, abort               - begin a game / return to IDLE (abort wins)
//   sel_valid/player/card      - card-play request
//   sel_accept, sel_reject     - one-cycle response pulses
//   err_code                   - last reject reason
//   state, leader, lead_black  - FSM state, round leader, leader card colour
//   round, p1_wins, p2_wins    - rounds completed and wins per player
//   p*_mask, p*_black/white    - unused cards per player
//   match_result, game_result  - last round outcome, game outcome
//   done                       - high while in DONE
module baw_match_engine
    import baw_pkg::*;
#(
    parameter int unsigned NUM_CARDS  = 9,
    parameter int unsigned NUM_ROUNDS = NUM_CARDS,
    localparam int unsigned CW        = $clog2(NUM_CARDS),
    localparam int unsigned RW        = $clog2(NUM_ROUNDS + 1),
    localparam int unsigned NW        = $clog2(NUM_CARDS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 sel_valid,
    input  logic                 sel_player,
    input  logic [CW-1:0]        sel_card,
    output logic                 sel_accept,
    output logic                 sel_reject,
    output logic [1:0]           err_code,
    output logic [2:0]           state,
    output logic                 leader,
    output logic                 lead_black,
    output logic [RW-1:0]        round,
    output logic [RW-1:0]        p1_wins,
    output logic [RW-1:0]        p2_wins,
    output logic [NUM_CARDS-1:0] p1_mask,
    output logic [NUM_CARDS-1:0] p2_mask,
    output logic [NW-1:0]        p1_black,
    output logic [NW-1:0]        p1_white,
    output logic [NW-1:0]        p2_black,
    output logic [NW-1:0]        p2_white,
    output logic [1:0]           match_result,
    output logic [1:0]           game_result,
    output logic                 done
);

    localparam logic [CW:0]   CARD_LIMIT = (CW + 1)'(NUM_CARDS);
    localparam logic [RW-1:0] ROUND_LIM  = RW'(NUM_ROUNDS);

    state_t         state_q;
    logic [CW-1:0]  lead_card_q;
    logic [CW-1:0]  follow_card_q;

    logic           play_phase_c;
    logic           exp_player_c;
    logic           req_c;
    logic           accept_c;
    logic           start_c;
    logic [1:0]     reject_code_c;
    logic [NUM_CARDS-1:0] req_mask_c;

    logic [CW-1:0]  p1_card_c;
    logic [CW-1:0]  p2_card_c;
    logic [1:0]     round_res_c;
    logic [1:0]     final_res_c;
    logic [RW-1:0]  p1_wins_n_c;
    logic [RW-1:0]  p2_wins_n_c;
    logic [RW-1:0]  round_n_c;
    logic [RW-1:0]  diff_c;
    logic [RW-1:0]  remain_c;
    logic           game_over_c;

    assign state = state_q;

    // Request qualification; reject reasons checked in priority order
    always_comb begin
        play_phase_c  = (state_q == ST_LEAD) || (state_q == ST_FOLLOW);
        exp_player_c  = (state_q == ST_FOLLOW) ? ~leader : leader;
        req_mask_c    = sel_player ? p2_mask : p1_mask;
        req_c         = sel_valid && !abort && play_phase_c;
        reject_code_c = ERR_NONE;
        if (sel_player != exp_player_c) begin
            reject_code_c = ERR_TURN;
        end else if ({1'b0, sel_card} >= CARD_LIMIT) begin
            reject_code_c = ERR_RANGE;
        end else if (!req_mask_c[sel_card]) begin
            reject_code_c = ERR_USED;
        end
        accept_c = req_c && (reject_code_c == ERR_NONE);
        start_c  = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    // Round resolution with the post-round counter values used for end-of-game test
    always_comb begin
        p1_card_c = leader ? follow_card_q : lead_card_q;
        p2_card_c = leader ? lead_card_q   : follow_card_q;
        if (p1_card_c > p2_card_c) begin
            round_res_c = RES_P1;
        end else if (p2_card_c > p1_card_c) begin
            round_res_c = RES_P2;
        end else begin
            round_res_c = RES_TIE;
        end
        p1_wins_n_c = p1_wins + RW'(round_res_c == RES_P1);
        p2_wins_n_c = p2_wins + RW'(round_res_c == RES_P2);
        round_n_c   = round + RW'(1);
        diff_c      = (p1_wins_n_c >= p2_wins_n_c) ? (p1_wins_n_c - p2_wins_n_c)
                                                   : (p2_wins_n_c - p1_wins_n_c);
        remain_c    = ROUND_LIM - round_n_c;
        game_over_c = (round_n_c == ROUND_LIM) || (diff_c > remain_c);
        if (p1_wins_n_c > p2_wins_n_c) begin
            final_res_c = RES_P1;
        end else if (p2_wins_n_c > p1_wins_n_c) begin
            final_res_c = RES_P2;
        end else begin
            final_res_c = RES_TIE;
        end
    end

    // Game FSM with registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            lead_card_q   <= '0;
            follow_card_q <= '0;
            sel_accept    <= 1'b0;
            sel_reject    <= 1'b0;
            err_code      <= ERR_NONE;
            leader        <= 1'b0;
            lead_black    <= 1'b0;
            round         <= '0;
            p1_wins       <= '0;
            p2_wins       <= '0;
            match_result  <= RES_NONE;
            game_result   <= RES_NONE;
            done          <= 1'b0;
        end else begin
            sel_accept <= 1'b0;
            sel_reject <= 1'b0;
            if (abort) begin
                // Counters and results stay visible in IDLE
                state_q <= ST_IDLE;
                done    <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (start_c) begin
                            state_q       <= ST_LEAD;
                            lead_card_q   <= '0;
                            follow_card_q <= '0;
                            err_code      <= ERR_NONE;
                            leader        <= 1'b0;
                            lead_black    <= 1'b0;
                            round         <= '0;
                            p1_wins       <= '0;
                            p2_wins       <= '0;
                            match_result  <= RES_NONE;
                            game_result   <= RES_NONE;
                            done          <= 1'b0;
                        end
                    end
                    ST_LEAD, ST_FOLLOW: begin
                        if (accept_c) begin
                            sel_accept <= 1'b1;
                            err_code   <= ERR_NONE;
                            if (state_q == ST_LEAD) begin
                                lead_card_q <= sel_card;
                                lead_black  <= sel_card[0];
                                state_q     <= ST_FOLLOW;
                            end else begin
                                follow_card_q <= sel_card;
                                state_q       <= ST_RESOLVE;
                            end
                        end else if (req_c) begin
                            sel_reject <= 1'b1;
                            err_code   <= reject_code_c;
                        end
                    end
                    ST_RESOLVE: begin
                        match_result <= round_res_c;
                        p1_wins      <= p1_wins_n_c;
                        p2_wins      <= p2_wins_n_c;
                        round        <= round_n_c;
                        // A tie leaves the leader unchanged
                        if (round_res_c == RES_P1) begin
                            leader <= 1'b0;
                        end else if (round_res_c == RES_P2) begin
                            leader <= 1'b1;
                        end
                        if (game_over_c) begin
                            state_q     <= ST_DONE;
                            game_result <= final_res_c;
                            done        <= 1'b1;
                        end else begin
                            state_q <= ST_LEAD;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    baw_hand #(
        .NUM_CARDS (NUM_CARDS),
        .CW        (CW),
        .NW        (NW)
    ) u_hand_p1 (
        .clk       (clk),
        .reset     (reset),
        .load      (start_c),
        .take      (accept_c && !sel_player),
        .card      (sel_card),
        .mask      (p1_mask),
        .black_cnt (p1_black),
        .white_cnt (p1_white)
    );

    baw_hand #(
        .NUM_CARDS (NUM_CARDS),
        .CW        (CW),
        .NW        (NW)
    ) u_hand_p2 (
        .clk       (clk),
        .reset     (reset),
        .load      (start_c),
        .take      (accept_c && sel_player),
        .card      (sel_card),
        .mask      (p2_mask),
        .black_cnt (p2_black),
        .white_cnt (p2_white)
    );

endmodule

// File: tb/tb_baw_match_engine.sv
// Scoreboard bench for baw_match_engine: default 9-card instance (a_*) and a
// 4-card/3-round instance (b_*). Play responses are queued when issued and
// checked by per-instance monitors; game state is checked inline.
module tb_baw_match_engine;

    localparam logic [2:0] ACC     = 3'b100;
    localparam logic [2:0] R_TURN  = 3'b001;
    localparam logic [2:0] R_RANGE = 3'b010;
    localparam logic [2:0] R_USED  = 3'b011;
    localparam logic [2:0] NONE    = 3'b000;

    logic clk = 1'b0;
    logic reset;

    // default instance
    logic       a_start, a_abort, a_sv, a_sp;
    logic [3:0] a_sc;
    logic       a_acc, a_rej, a_leader, a_lb, a_done;
    logic [1:0] a_err, a_mr, a_gr;
    logic [2:0] a_state;
    logic [3:0] a_round, a_p1w, a_p2w;
    logic [8:0] a_p1m, a_p2m;
    logic [3:0] a_p1b, a_p1wh, a_p2b, a_p2wh;

    // small instance
    logic       b_start, b_abort, b_sv, b_sp;
    logic [1:0] b_sc;
    logic       b_acc, b_rej, b_leader, b_lb, b_done;
    logic [1:0] b_err, b_mr, b_gr;
    logic [2:0] b_state;
    logic [1:0] b_round, b_p1w, b_p2w;
    logic [3:0] b_p1m, b_p2m;
    logic [2:0] b_p1b, b_p1wh, b_p2b, b_p2wh;

    logic [2:0] exp_a[$];
    logic [2:0] exp_b[$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    baw_match_engine dut_a (
        .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
        .sel_valid(a_sv), .sel_player(a_sp), .sel_card(a_sc),
        .sel_accept(a_acc), .sel_reject(a_rej), .err_code(a_err),
        .state(a_state), .leader(a_leader), .lead_black(a_lb),
        .round(a_round), .p1_wins(a_p1w), .p2_wins(a_p2w),
        .p1_mask(a_p1m), .p2_mask(a_p2m),
        .p1_black(a_p1b), .p1_white(a_p1wh), .p2_black(a_p2b), .p2_white(a_p2wh),
        .match_result(a_mr), .game_result(a_gr), .done(a_done)
    );

    baw_match_engine #(.NUM_CARDS(4), .NUM_ROUNDS(3)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
        .sel_valid(b_sv), .sel_player(b_sp), .sel_card(b_sc),
        .sel_accept(b_acc), .sel_reject(b_rej), .err_code(b_err),
        .state(b_state), .leader(b_leader), .lead_black(b_lb),
        .round(b_round), .p1_wins(b_p1w), .p2_wins(b_p2w),
        .p1_mask(b_p1m), .p2_mask(b_p2m),
        .p1_black(b_p1b), .p1_white(b_p1wh), .p2_black(b_p2b), .p2_white(b_p2wh),
        .match_result(b_mr), .game_result(b_gr), .done(b_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request for one cycle; queue the expected response if any
    task automatic play(input bit d, input bit p, input int card, input bit push, input logic [2:0] exp);
        if (push) begin
            if (d) exp_b.push_back(exp);
            else   exp_a.push_back(exp);
        end
        if (!d) begin
            a_sv = 1'b1; a_sp = p; a_sc = 4'(card);
        end else begin
            b_sv = 1'b1; b_sp = p; b_sc = 2'(card);
        end
        tick();
        a_sv = 1'b0;
        b_sv = 1'b0;
    endtask

    task automatic start_game(input bit d);
        if (d) b_start = 1'b1; else a_start = 1'b1;
        tick();
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic abort_a();
        a_abort = 1'b1;
        tick();
        a_abort = 1'b0;
    endtask

    // Monitor: every response pulse must match the oldest queued expectation
    initial begin
        logic [2:0] got;
        forever begin
            @(negedge clk);
            if (a_acc || a_rej) begin
                got = a_acc ? ACC : {1'b0, a_err};
                if (a_acc && a_rej) chk("A both pulses", 32'(got), 32'(3'b111));
                if (exp_a.size() == 0) chk("A unexpected pulse", 32'(got), 32'(NONE));
                else chk("A response", 32'(got), 32'(exp_a.pop_front()));
            end
        end
    end

    initial begin
        logic [2:0] got;
        forever begin
            @(negedge clk);
            if (b_acc || b_rej) begin
                got = b_acc ? ACC : {1'b0, b_err};
                if (b_acc && b_rej) chk("B both pulses", 32'(got), 32'(3'b111));
                if (exp_b.size() == 0) chk("B unexpected pulse", 32'(got), 32'(NONE));
                else chk("B response", 32'(got), 32'(exp_b.pop_front()));
            end
        end
    end

    initial begin
        int p1c[4] = '{4, 5, 6, 7};
        int p2c[4] = '{0, 1, 2, 6};

        reset = 1'b1;
        a_start = 0; a_abort = 0; a_sv = 0; a_sp = 0; a_sc = '0;
        b_start = 0; b_abort = 0; b_sv = 0; b_sp = 0; b_sc = '0;
        #12;
        chk("A reset state", 32'(a_state), 0);
        chk("A reset p1_mask", 32'(a_p1m), 32'h1FF);
        chk("A reset p2 black", 32'(a_p2b), 4);
        chk("A reset p2 white", 32'(a_p2wh), 5);
        chk("A reset round", 32'(a_round), 0);
        chk("A reset outputs", 32'({a_acc, a_rej, a_err, a_mr, a_gr, a_done, a_leader}), 0);
        chk("B reset mask", 32'(b_p1m), 32'hF);
        chk("B reset black/white", 32'({b_p1b, b_p1wh}), 32'({3'd2, 3'd2}));
        @(posedge clk); #1;
        reset = 1'b0;
        tick();

        // request in IDLE is ignored
        play(0, 0, 8, 0, NONE);
        chk("A idle ignore state", 32'(a_state), 0);

        start_game(0);
        chk("A start state", 32'(a_state), 1);
        chk("A start leader", 32'(a_leader), 0);

        play(0, 1, 3, 1, R_TURN);
        chk("A state after wrong turn", 32'(a_state), 1);
        play(0, 0, 9, 1, R_RANGE);
        chk("A state after range", 32'(a_state), 1);
        play(0, 0, 8, 1, ACC);
        chk("A follow state", 32'(a_state), 2);
        chk("A lead_black", 32'(a_lb), 0);
        chk("A p1_mask after 8", 32'(a_p1m), 32'h0FF);
        chk("A p1 white after 8", 32'(a_p1wh), 4);
        play(0, 0, 2, 1, R_TURN);
        chk("A state follow wrong turn", 32'(a_state), 2);
        play(0, 1, 3, 1, ACC);
        chk("A resolve state", 32'(a_state), 3);
        chk("A p2 black after 3", 32'(a_p2b), 3);
        chk("A p2_mask after 3", 32'(a_p2m), 32'h1F7);
        tick();
        chk("A r1 state", 32'(a_state), 1);
        chk("A r1 match_result", 32'(a_mr), 1);
        chk("A r1 p1_wins", 32'(a_p1w), 1);
        chk("A r1 round", 32'(a_round), 1);
        chk("A r1 leader", 32'(a_leader), 0);

        play(0, 0, 8, 1, R_USED);
        chk("A state after used", 32'(a_state), 1);

        // P1 takes rounds 2..5; game decided early
        for (int i = 0; i < 4; i++) begin
            play(0, 0, p1c[i], 1, ACC);
            play(0, 1, p2c[i], 1, ACC);
            tick();
            chk("A p1 round result", 32'(a_mr), 1);
            chk("A p1 round state", 32'(a_state), (i == 3) ? 4 : 1);
        end
        chk("A early done", 32'(a_done), 1);
        chk("A early game_result", 32'(a_gr), 1);
        chk("A early round", 32'(a_round), 5);
        chk("A early p1_wins", 32'(a_p1w), 5);

        play(0, 0, 0, 0, NONE);
        chk("A done holds", 32'({a_state, a_done}), 32'({3'd4, 1'b1}));
        abort_a();
        chk("A abort state", 32'(a_state), 0);
        chk("A abort keeps round", 32'(a_round), 5);
        chk("A abort done low", 32'(a_done), 0);

        // nine tied rounds
        start_game(0);
        chk("A restart mask", 32'(a_p1m), 32'h1FF);
        chk("A restart counters", 32'({a_round, a_mr, a_gr}), 0);
        for (int i = 0; i < 9; i++) begin
            play(0, 0, i, 1, ACC);
            play(0, 1, i, 1, ACC);
            tick();
            chk("A tie result", 32'(a_mr), 3);
            chk("A tie leader", 32'(a_leader), 0);
        end
        chk("A tie state", 32'(a_state), 4);
        chk("A tie game_result", 32'(a_gr), 3);
        chk("A tie round", 32'(a_round), 9);
        chk("A tie wins", 32'({a_p1w, a_p2w}), 0);

        // abort outranks a simultaneous legal play
        abort_a();
        start_game(0);
        play(0, 0, 5, 1, ACC);
        a_abort = 1'b1;
        play(0, 1, 3, 0, NONE);
        a_abort = 1'b0;
        chk("A abort vs play state", 32'(a_state), 0);
        chk("A abort vs play p2_mask", 32'(a_p2m), 32'h1FF);
        chk("A abort vs play p1_mask", 32'(a_p1m), 32'h1DF);

        // asynchronous reset while in FOLLOW
        start_game(0);
        play(0, 0, 8, 1, ACC);
        chk("A pre-reset state", 32'(a_state), 2);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("A async reset state", 32'(a_state), 0);
        chk("A async reset mask", 32'(a_p1m), 32'h1FF);
        chk("A async reset colours", 32'({a_p1b, a_p1wh}), 32'({4'd4, 4'd5}));
        chk("A async reset pulses", 32'({a_acc, a_rej, a_lb}), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) tick();
        chk("A post-reset state", 32'(a_state), 0);

        // small configuration: P2 wins, then leads
        start_game(1);
        play(1, 0, 1, 1, ACC);
        play(1, 1, 3, 1, ACC);
        tick();
        chk("B r1 match_result", 32'(b_mr), 2);
        chk("B r1 leader", 32'(b_leader), 1);
        chk("B r1 state", 32'(b_state), 1);
        play(1, 0, 0, 1, R_TURN);
        chk("B state after wrong turn", 32'(b_state), 1);
        play(1, 1, 2, 1, ACC);
        chk("B follow state", 32'(b_state), 2);
        play(1, 0, 0, 1, ACC);
        tick();
        chk("B early done state", 32'(b_state), 4);
        chk("B game_result", 32'(b_gr), 2);
        chk("B wins/round", 32'({b_p2w, b_round}), 32'({2'd2, 2'd2}));

        repeat (3) tick();
        chk("A queue drained", 32'(exp_a.size()), 0);
        chk("B queue drained", 32'(exp_b.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
